// File: rtl/bin2bcd_defs.sv
// Shared definitions for the binary-to-BCD display converter: FSM encodings and digit constants.
package bin2bcd_defs;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_ERR_DIGIT = 4'hE;

   typedef enum logic [1:0] {
      S_IDLE  = 2'h0,
      S_SHIFT = 2'h1,
      S_DONE  = 2'h2
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell for shift-and-add-3: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
   import bin2bcd_defs::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adj
);

   always_comb begin
      adj = digit;
      if (digit >= DIGIT_W'(5)) adj = digit + DIGIT_W'(3);
   end

endmodule

// File: rtl/bin2bcd_display_m1geo.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the MAX6951 data/dps inputs.
// Results land in output registers all at once, so the display never shows a partial value.
module bin2bcd_display_m1geo
   import bin2bcd_defs::*;
#(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
)
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic [DIGITS-1:0]     dps_in,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     dps_out,
   output logic                  ovf
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);
   localparam logic [63:0] LIMIT = 64'(10 ** DIGITS) - 64'd1;

   state_t             state, state_nxt;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   bcd_sr;
   logic [BCD_W-1:0]   bcd_adj;
   logic [DIGITS-1:0]  dps_q;
   logic               ovf_q;
   logic [CNT_W-1:0]   cnt;

   assign in_ready = (state == S_IDLE);

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (bcd_sr[g*DIGIT_W +: DIGIT_W]),
         .adj   (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Scratch registers and the display-facing output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bin_sr    <= '0;
         bcd_sr    <= '0;
         dps_q     <= '0;
         ovf_q     <= 1'b0;
         cnt       <= '0;
         bcd_out   <= '0;
         dps_out   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  bin_sr <= bin_in;
                  dps_q  <= dps_in;
                  ovf_q  <= (64'(bin_in) > LIMIT);
                  bcd_sr <= '0;
                  cnt    <= CNT_W'(BIN_W - 1);
               end
            end
            S_SHIFT: begin
               // Bits leaving the top BCD digit are dropped; only overflowing inputs produce them.
               {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            S_DONE: begin
               bcd_out   <= ovf_q ? {DIGITS{BCD_ERR_DIGIT}} : bcd_sr;
               dps_out   <= dps_q;
               ovf       <= ovf_q;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_display_m1geo.sv
// Directed and random checks of bin2bcd_display_m1geo against a decimal reference model.
module tb_bin2bcd_display_m1geo;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [26:0] bin_in = '0;
   logic [7:0]  dps_in = '0;
   logic        out_valid;
   logic [31:0] bcd_out;
   logic [7:0]  dps_out;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   bin2bcd_display_m1geo #(.BIN_W(27), .DIGITS(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .dps_in    (dps_in),
      .out_valid (out_valid),
      .bcd_out   (bcd_out),
      .dps_out   (dps_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [26:0] bin;
      logic [7:0]  dps;
      logic [31:0] bcd;
      logic        ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      if (v > 99_999_999) return 32'hEEEEEEEE;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Launch one conversion from a negedge, return cycles from accept to out_valid and in_ready-low count.
   task automatic do_conv(input logic [26:0] b, input logic [7:0] d, output int lat, output int busy);
      int k;
      lat = -1;
      busy = 0;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      in_valid = 1'b1;
      bin_in = b;
      dps_in = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      bin_in = 27'h5A5A5A5;
      dps_in = 8'h3C;
      if (!in_ready) busy++;
      for (int e = 1; e <= 60; e++) begin
         @(negedge clk);
         if (!in_ready) busy++;
         if (out_valid) begin
            lat = e;
            break;
         end
      end
      n_cmp++;
      if (lat < 0) begin
         n_err++;
         $display("FAIL conv_timeout: no out_valid for 0x%07h within 60 cycles", b);
      end
   endtask

   vec_t vecs[8];
   int lat, busy, c0, c1, pulses;
   logic [26:0] rv;

   initial begin
      vecs[0] = '{27'd0,           8'h00, 32'h00000000, 1'b0};
      vecs[1] = '{27'd12_345_678,  8'hA5, 32'h12345678, 1'b0};
      vecs[2] = '{27'd99_999_999,  8'hFF, 32'h99999999, 1'b0};
      vecs[3] = '{27'd100_000_000, 8'h3C, 32'hEEEEEEEE, 1'b1};
      vecs[4] = '{27'd134_217_727, 8'h01, 32'hEEEEEEEE, 1'b1};
      vecs[5] = '{27'd9,           8'h80, 32'h00000009, 1'b0};
      vecs[6] = '{27'd10,          8'h02, 32'h00000010, 1'b0};
      vecs[7] = '{27'd90_807_060,  8'h55, 32'h90807060, 1'b0};

      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_bcd_out", bcd_out, 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_ovf", 32'(ovf), 32'd0);

      for (int i = 0; i < 8; i++) begin
         do_conv(vecs[i].bin, vecs[i].dps, lat, busy);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd28);
         chk($sformatf("v%0d_bcd", i), bcd_out, vecs[i].bcd);
         chk($sformatf("v%0d_dps", i), 32'(dps_out), 32'(vecs[i].dps));
         chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
         if (i == 1) chk("v1_busy_cycles", 32'(busy), 32'd28);
         @(negedge clk);
         chk($sformatf("v%0d_pulse_width", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_hold_bcd", i), bcd_out, vecs[i].bcd);
      end

      // in_valid held high with data churning; only 7 and 42 are sampled while ready.
      @(negedge clk);
      in_valid = 1'b1;
      bin_in = 27'd7;
      dps_in = 8'h00;
      @(posedge clk);
      c0 = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (out_valid) begin
            c0 = cyc;
            break;
         end
         bin_in = 27'(1000 + k * 7777);
      end
      chk("b2b_first_seen", 32'(c0 >= 0), 32'd1);
      chk("b2b_first_bcd", bcd_out, 32'h00000007);
      chk("b2b_ready_on_pulse", 32'(in_ready), 32'd1);
      bin_in = 27'd42;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      bin_in = 27'd999;
      chk("b2b_no_double_pulse", 32'(out_valid), 32'd0);
      c1 = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (out_valid) begin
            c1 = cyc;
            break;
         end
      end
      chk("b2b_second_bcd", bcd_out, 32'h00000042);
      chk("b2b_spacing", 32'(c1 - c0), 32'd29);

      // Reset in the middle of converting 555 aborts without a pulse.
      @(negedge clk);
      in_valid = 1'b1;
      bin_in = 27'd555;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("abort_bcd", bcd_out, 32'h0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      pulses = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("abort_no_pulse", 32'(pulses), 32'd0);
      chk("abort_bcd_hold", bcd_out, 32'h0);
      do_conv(27'd555, 8'h00, lat, busy);
      chk("after_abort_bcd", bcd_out, 32'h00000555);
      chk("after_abort_latency", 32'(lat), 32'd28);

      for (int i = 0; i < 1000; i++) begin
         rv = 27'($urandom_range(134_217_727, 0));
         do_conv(rv, rv[7:0], lat, busy);
         chk($sformatf("rnd_bcd_%0d", rv), bcd_out, ref_bcd(32'(rv)));
         chk($sformatf("rnd_ovf_%0d", rv), 32'(ovf), 32'(rv > 27'd99_999_999));
         chk($sformatf("rnd_dps_%0d", rv), 32'(dps_out), 32'(rv[7:0]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
